// File: rtl/fft_pkg.sv
// Shared FFT parameters and the bit-reverse stream controller state type.
package fft_pkg;
    localparam int FFT_LGSIZE = 5;
    localparam int FFT_WIDTH  = 24;

    typedef enum logic [2:0] {
        PRIME,
        RUN,
        PAD,
        DRAIN,
        CLEAR
    } brev_state_e;
endpackage

// File: rtl/bitreverse.sv
// Ping-pong bit-reverse core: one bank fills in natural order while the
// other is read out at bit-reversed addresses, one word per clock enable.
module bitreverse
    import fft_pkg::*;
#(
    parameter int LGSIZE = FFT_LGSIZE,
    parameter int WIDTH  = FFT_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_ce,
    input  logic [2*WIDTH-1:0] i_in,
    output logic [2*WIDTH-1:0] o_out,
    output logic               o_sync
);
    localparam int N = 1 << LGSIZE;

    logic [2*WIDTH-1:0] mem [0:2*N-1];
    logic [LGSIZE:0]    wcnt;
    logic [LGSIZE-1:0]  rrev;
    logic [LGSIZE:0]    raddr;

    always_comb begin
        rrev = '0;
        for (int i = 0; i < LGSIZE; i++) begin
            rrev[i] = wcnt[LGSIZE-1-i];
        end
    end

    // Top address bit selects the bank; read the bank not being written.
    assign raddr  = {~wcnt[LGSIZE], rrev};
    assign o_out  = mem[raddr];
    assign o_sync = (wcnt[LGSIZE-1:0] == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wcnt <= '0;
        end else if (i_ce) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            mem[wcnt] <= i_in;
        end
    end
endmodule

// File: rtl/bitreverse_stream_ctrl.sv
// Valid/ready wrapper around the bit-reverse core: priming, stalls,
// end-of-stream pad/drain and frame markers.
module bitreverse_stream_ctrl
    import fft_pkg::*;
#(
    parameter int LGSIZE = FFT_LGSIZE,
    parameter int WIDTH  = FFT_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [2*WIDTH-1:0] s_data,
    input  logic               s_last,
    input  logic               i_flush,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [2*WIDTH-1:0] m_data,
    output logic               m_first,
    output logic               m_last,
    output logic               o_busy,
    output logic               o_err
);
    localparam logic [LGSIZE-1:0] POS_LAST = '1;

    brev_state_e        state;
    brev_state_e        state_nx;
    logic [LGSIZE-1:0]  wpos;
    logic [LGSIZE-1:0]  opos;
    logic [LGSIZE-1:0]  cnt;
    logic               primed;
    logic               flush_req;
    logic               adv;
    logic               feed;
    logic               ce;
    logic               core_clr;
    logic               core_rst;
    logic               core_sync;
    logic               flush_ok;
    logic [2*WIDTH-1:0] core_in;
    logic [2*WIDTH-1:0] core_out;

    // A pending flush closes the input so the next state sees a fixed wpos.
    always_comb begin
        adv      = !m_valid || m_ready;
        feed     = (state == PRIME || state == RUN) && !flush_req;
        ce       = adv && ((state == PAD || state == DRAIN) || (feed && s_valid));
        s_ready  = adv && feed;
        core_in  = feed ? s_data : '0;
        core_clr = (state == CLEAR) && adv;
        o_busy   = (state != PRIME) || (wpos != '0);
        flush_ok = (state == RUN) || (state == PRIME && (wpos != '0 || ce));
    end

    assign core_rst = i_reset || core_clr;

    bitreverse #(
        .LGSIZE(LGSIZE),
        .WIDTH (WIDTH)
    ) u_brev (
        .i_clk  (i_clk),
        .i_reset(core_rst),
        .i_ce   (ce),
        .i_in   (core_in),
        .o_out  (core_out),
        .o_sync (core_sync)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            PRIME: begin
                if (flush_req && wpos != '0) state_nx = PAD;
                else if (ce && wpos == POS_LAST) state_nx = RUN;
            end
            RUN: begin
                if (flush_req) state_nx = (wpos == '0) ? DRAIN : PAD;
            end
            PAD: begin
                if (ce && wpos == POS_LAST) state_nx = DRAIN;
            end
            DRAIN: begin
                if (ce && cnt == '0) state_nx = CLEAR;
            end
            CLEAR: begin
                if (adv) state_nx = PRIME;
            end
            default: state_nx = PRIME;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= PRIME;
            wpos      <= '0;
            opos      <= '0;
            cnt       <= '0;
            primed    <= 1'b0;
            flush_req <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_first   <= 1'b0;
            m_last    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state <= state_nx;
            o_err <= ce && feed && (s_last != (wpos == POS_LAST));

            if (core_clr) begin
                wpos   <= '0;
                opos   <= '0;
                primed <= 1'b0;
            end else if (ce) begin
                wpos <= wpos + 1'b1;
                if (wpos == POS_LAST) primed <= 1'b1;
            end

            if (state_nx == DRAIN && state != DRAIN) begin
                cnt <= POS_LAST;
            end else if (state == DRAIN && ce) begin
                cnt <= cnt - 1'b1;
            end

            if ((state_nx == PAD || state_nx == DRAIN) && state_nx != state) begin
                flush_req <= 1'b0;
            end else if (i_flush && flush_ok) begin
                flush_req <= 1'b1;
            end else if (state == PRIME && wpos == '0) begin
                flush_req <= 1'b0;
            end

            // Output register: loads on every advance, holds under backpressure.
            if (ce) begin
                m_valid <= primed;
                m_data  <= core_out;
                m_first <= core_sync;
                m_last  <= (opos == POS_LAST);
                if (primed) opos <= opos + 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    a_first_at_opos0: assert property (@(posedge i_clk) disable iff (i_reset)
        (ce && primed) |-> (core_sync == (opos == '0)));
endmodule

// File: tb/tb_bitreverse_stream_ctrl.sv
// Self-checking bench: vector table, directed corner cases and random
// streams against a frame-level reference model.
module tb_bitreverse_stream_ctrl;
    localparam int LG = 3;
    localparam int N  = 8;
    localparam int W  = 8;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          s_valid;
    logic          s_ready;
    logic [2*W-1:0] s_data;
    logic          s_last;
    logic          i_flush;
    logic          m_valid;
    logic          m_ready;
    logic [2*W-1:0] m_data;
    logic          m_first;
    logic          m_last;
    logic          o_busy;
    logic          o_err;

    bitreverse_stream_ctrl #(.LGSIZE(LG), .WIDTH(W)) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_last (s_last),
        .i_flush(i_flush),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_first(m_first),
        .m_last (m_last),
        .o_busy (o_busy),
        .o_err  (o_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int out_idx = 0;
    bit err_exp = 0;
    bit prev_stall = 0;
    logic [2*W-1:0] prev_data;
    logic [2*W-1:0] in_buf[$];
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] got[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic logic [2*W-1:0] samp(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {b, ~b};
    endfunction

    function automatic int rev(input int j);
        int r = 0;
        for (int b = 0; b < LG; b++) r = (r << 1) | ((j >> b) & 1);
        return r;
    endfunction

    // A completed frame leaves the block in bit-reversed index order.
    function automatic void emit();
        for (int j = 0; j < N; j++) exp_q.push_back(in_buf[rev(j)]);
        in_buf.delete();
    endfunction

    always @(negedge i_clk) begin
        if (i_reset) begin
            in_buf.delete();
            exp_q.delete();
            out_idx = 0;
            err_exp = 0;
            prev_stall = 0;
        end else begin
            chk("o_err", 32'(o_err), 32'(err_exp));
            if (o_err) err_pulses++;
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && !m_ready) chk("stall_s_ready", 32'(s_ready), 32'd0);
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: actual %0h required none", m_data);
                end else begin
                    chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
                chk("m_first", 32'(m_first), 32'(out_idx == 0));
                chk("m_last", 32'(m_last), 32'(out_idx == N-1));
                out_idx = (out_idx + 1) % N;
                got.push_back(m_data);
            end
            err_exp = 0;
            if (s_valid && s_ready) begin
                err_exp = (s_last != (in_buf.size() == N-1));
                in_buf.push_back(s_data);
                if (in_buf.size() == N) emit();
            end
            if (i_flush && in_buf.size() != 0) begin
                while (in_buf.size() < N) in_buf.push_back('0);
                emit();
            end
        end
    end

    task automatic send(input int base, input int n, input int vp, input int rp,
                        input int bad, input bit chk_mv0);
        int i = 0;
        int cyc = 0;
        bit hs;
        while (i < n && cyc < 2000) begin
            s_valid = ($urandom_range(0, 99) < vp);
            s_data  = samp(base + i);
            s_last  = (bad >= 0) ? (i == bad) : (in_buf.size() == N-1);
            m_ready = ($urandom_range(0, 99) < rp);
            @(negedge i_clk);
            hs = s_valid && s_ready;
            if (chk_mv0) chk("prime_m_valid", 32'(m_valid), 32'd0);
            @(posedge i_clk);
            #1;
            if (hs) i++;
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("send_timeout_sent", 32'(i), 32'(n));
    endtask

    task automatic flush();
        s_valid = 1'b0;
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
    endtask

    task automatic wait_idle(input int rp);
        bit done = 0;
        for (int c = 0; c < 600 && !done; c++) begin
            m_ready = ($urandom_range(0, 99) < rp);
            @(negedge i_clk);
            if (!o_busy && !m_valid) done = 1;
            @(posedge i_clk);
            #1;
        end
        chk("idle_reached", 32'(done), 32'd1);
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        bit rst;
        bit sv;
        int k;
        bit mr;
        bit mv;
        bit sr;
        bit busy;
        int dk;
    } vec_t;

    vec_t tbl[19];
    logic [2*W-1:0] pf[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 0, 0, 1, 0, 1, 0, 0};
        for (int j = 0; j < 8; j++) tbl[1+j] = '{0, 1, j, 1, 0, 1, (j != 0), 0};
        tbl[9]  = '{0, 1, 8, 1, 0, 1, 1, 0};
        tbl[10] = '{0, 1, 9, 1, 1, 1, 1, 0};
        tbl[11] = '{0, 1, 10, 1, 1, 1, 1, 4};
        for (int j = 0; j < 5; j++) tbl[12+j] = '{0, 1, 11, 0, 1, 0, 1, 2};
        tbl[17] = '{0, 1, 11, 1, 1, 1, 1, 2};
        tbl[18] = '{0, 1, 12, 1, 1, 1, 1, 6};
        pf = '{samp(8), 0, samp(10), 0, samp(9), 0, 0, 0};

        i_reset = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        i_flush = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;

        // Priming, first outputs and a 5-cycle stall
        for (int i = 0; i < 19; i++) begin
            i_reset = tbl[i].rst;
            s_valid = tbl[i].sv;
            s_data  = samp(tbl[i].k);
            s_last  = (tbl[i].k % N == N-1);
            m_ready = tbl[i].mr;
            @(negedge i_clk);
            chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
            chk($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].sr));
            chk($sformatf("vec%0d_o_busy", i), 32'(o_busy), 32'(tbl[i].busy));
            if (tbl[i].mv) chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(samp(tbl[i].dk)));
            if (tbl[i].rst) begin
                chk("reset_o_err", 32'(o_err), 32'd0);
                chk("reset_m_first", 32'(m_first), 32'd0);
                chk("reset_m_last", 32'(m_last), 32'd0);
            end
            @(posedge i_clk);
            #1;
        end

        // Continuous stream 0..23 then flush
        send(13, 11, 100, 100, -1, 0);
        flush();
        wait_idle(100);
        chk("cont_count", 32'(got.size()), 32'd24);
        if (got.size() == 24) begin
            chk("cont_out1", 32'(got[1]), 32'(samp(4)));
            chk("cont_out8", 32'(got[8]), 32'(samp(8)));
            chk("cont_out23", 32'(got[23]), 32'(samp(23)));
        end

        // Partial frame flush
        got.delete();
        send(0, 11, 100, 100, -1, 0);
        flush();
        wait_idle(100);
        chk("pflush_count", 32'(got.size()), 32'd16);
        if (got.size() == 16) begin
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("pflush_out%0d", 8+j), 32'(got[8+j]), 32'(pf[j]));
            end
        end

        // Bad framing: s_last early, then missing at N-1
        err_pulses = 0;
        send(40, 8, 100, 100, 5, 0);
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        chk("err_pulses", 32'(err_pulses), 32'd2);
        flush();
        wait_idle(100);

        // Mid-frame reset, then idle input while running
        send(0, 13, 100, 100, -1, 0);
        i_reset = 1'b1;
        repeat (2) begin
            @(posedge i_clk);
            #1;
        end
        i_reset = 1'b0;
        send(100, 9, 100, 100, -1, 1);
        m_ready = 1'b1;
        @(negedge i_clk);
        chk("rst_first_valid", 32'(m_valid), 32'd1);
        chk("rst_first_data", 32'(m_data), 32'(samp(100)));
        @(posedge i_clk);
        #1;
        for (int c = 0; c < 19; c++) begin
            @(negedge i_clk);
            chk("idle_m_valid", 32'(m_valid), 32'd0);
            @(posedge i_clk);
            #1;
        end
        send(109, 7, 100, 100, -1, 0);
        flush();
        wait_idle(100);

        // Random valid/ready streams of random length, each ended by a flush
        for (int r = 0; r < 8; r++) begin
            int m;
            int vp;
            int rp;
            m  = $urandom_range(0, 20);
            vp = $urandom_range(30, 100);
            rp = $urandom_range(30, 100);
            send(r * 29, m, vp, rp, -1, 0);
            flush();
            wait_idle(rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
